// File: rtl/rv32i_types.sv
// +----------------------------------------------------------------------+
// | rv32i_types : shared RV32I front-end types and constants             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

    localparam logic [31:0] CPU_RESET_PC = 32'h1eceb000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_fifo.sv
// +----------------------------------------------------------------------+
// | fq_fifo  : fetch queue storage, {word, pc} entries with flush        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module fq_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fq_entry_t                push_data,
    output logic [$clog2(DEPTH):0]   count,
    output fq_entry_t                head
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [AW:0]     r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + AW'(1);
            if (pop)  r_rd <= r_rd + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr] <= push_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +----------------------------------------------------------------------+
// | fetch_queue : fetch PC, single-outstanding imem FSM and decode FIFO  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_queue
    import rv32i_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_next
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fq_entry_t     w_head;
    fq_entry_t     w_push_data;

    // Space counts the outstanding kept response; a same-cycle pop is ignored.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, (r_state == WAIT)};
    assign w_issue = rst && !redirect_valid
                     && ((r_state == IDLE) || imem_resp)
                     && (w_occ < (CW+1)'(DEPTH));
    assign w_push  = (r_state == WAIT) && imem_resp && !redirect_valid;
    assign w_pop   = inst_valid && inst_ready;

    assign w_push_data.inst = imem_rdata;
    assign w_push_data.pc   = r_req_pc;

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            if (r_state == IDLE) w_state_next = IDLE;
            else                 w_state_next = imem_resp ? IDLE : DROP;
        end else begin
            case (r_state)
                IDLE:    if (w_issue) w_state_next = WAIT;
                WAIT,
                DROP:    if (imem_resp) w_state_next = w_issue ? WAIT : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_issue) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .push_data (w_push_data),
        .count     (w_count),
        .head      (w_head)
    );

    assign imem_addr    = r_pc;
    assign imem_rmask   = w_issue ? 4'hF : 4'h0;
    assign inst_valid   = (w_count != '0) && !redirect_valid;
    assign inst         = w_head.inst;
    assign inst_pc      = w_head.pc;
    assign inst_pc_next = w_head.pc + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +----------------------------------------------------------------------+
// | tb_fetch_queue : directed self-checking bench for fetch_queue        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_next;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h1eceb000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_next   (inst_pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checking.
    task automatic cyc(input logic resp, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        imem_resp      = resp;
        imem_rdata     = rdata;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        imem_resp = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rmask", 32'(imem_rmask), 32'h0);
        chk("reset_valid", 32'(inst_valid), 32'h0);

        // Streaming with single-cycle imem and decode always ready
        @(negedge clk);
        rst = 1'b1; inst_ready = 1'b1;
        #1;
        chk("s0_rmask", 32'(imem_rmask), 32'hF);
        chk("s0_addr", imem_addr, 32'h1eceb000);
        cyc(1'b1, 32'hA0000000, 1'b1, 1'b0, 32'h0);
        chk("s1_addr", imem_addr, 32'h1eceb004);
        chk("s1_valid", 32'(inst_valid), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 32'hA0000000 + 32'(i), 1'b1, 1'b0, 32'h0);
            chk("st_valid", 32'(inst_valid), 32'h1);
            chk("st_inst", inst, 32'hA0000000 + 32'(i - 1));
            chk("st_pc", inst_pc, 32'h1eceb000 + 32'(4 * (i - 1)));
            chk("st_pcnext", inst_pc_next, 32'h1eceb004 + 32'(4 * (i - 1)));
            chk("st_rmask", 32'(imem_rmask), 32'hF);
            chk("st_addr", imem_addr, 32'h1eceb000 + 32'(4 * (i + 1)));
        end

        // Redirect coinciding with a response in WAIT: response dropped
        cyc(1'b1, 32'hA0000005, 1'b0, 1'b1, 32'h1eceb200);
        chk("rr_rmask", 32'(imem_rmask), 32'h0);
        chk("rr_valid", 32'(inst_valid), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rr_next_rmask", 32'(imem_rmask), 32'hF);
        chk("rr_next_addr", imem_addr, 32'h1eceb200);
        chk("rr_next_valid", 32'(inst_valid), 32'h0);

        // Backpressure from an empty FIFO: exactly four requests
        cyc(1'b1, 32'hB0000000, 1'b0, 1'b0, 32'h0);
        chk("bp1_addr", imem_addr, 32'h1eceb204);
        chk("bp1_rmask", 32'(imem_rmask), 32'hF);
        cyc(1'b1, 32'hB0000001, 1'b0, 1'b0, 32'h0);
        chk("bp2_rmask", 32'(imem_rmask), 32'hF);
        cyc(1'b1, 32'hB0000002, 1'b0, 1'b0, 32'h0);
        chk("bp3_rmask", 32'(imem_rmask), 32'hF);
        chk("bp3_addr", imem_addr, 32'h1eceb20c);
        chk("bp3_inst", inst, 32'hB0000000);
        cyc(1'b1, 32'hB0000003, 1'b0, 1'b0, 32'h0);
        chk("bp4_rmask", 32'(imem_rmask), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("bp5_rmask", 32'(imem_rmask), 32'h0);
        chk("bp5_valid", 32'(inst_valid), 32'h1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("bp6_rmask_no_ready_path", 32'(imem_rmask), 32'h0);
        chk("bp6_inst", inst, 32'hB0000000);
        chk("bp6_pc", inst_pc, 32'h1eceb200);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("bp7_rmask", 32'(imem_rmask), 32'hF);
        chk("bp7_addr", imem_addr, 32'h1eceb210);
        chk("bp7_inst", inst, 32'hB0000001);
        cyc(1'b1, 32'hB0000004, 1'b0, 1'b0, 32'h0);
        chk("bp8_rmask", 32'(imem_rmask), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("bp9_rmask", 32'(imem_rmask), 32'h0);

        // Drain; the second drain cycle frees a slot and issues 214
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("dr1_inst", inst, 32'hB0000001);
        chk("dr1_rmask", 32'(imem_rmask), 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("dr2_inst", inst, 32'hB0000002);
        chk("dr2_addr", imem_addr, 32'h1eceb214);
        chk("dr2_rmask", 32'(imem_rmask), 32'hF);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("dr3_pc", inst_pc, 32'h1eceb20c);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("dr4_inst", inst, 32'hB0000004);
        chk("dr4_pc", inst_pc, 32'h1eceb210);

        // Redirect during WAIT on a slow response; misaligned target
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h1eceb103);
        chk("wr_valid", 32'(inst_valid), 32'h0);
        chk("wr_rmask", 32'(imem_rmask), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("drop_rmask", 32'(imem_rmask), 32'h0);
        chk("drop_valid", 32'(inst_valid), 32'h0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        chk("stale_rmask", 32'(imem_rmask), 32'hF);
        chk("stale_addr", imem_addr, 32'h1eceb100);
        chk("stale_valid", 32'(inst_valid), 32'h0);
        cyc(1'b1, 32'hC0000000, 1'b0, 1'b0, 32'h0);
        chk("c0_valid", 32'(inst_valid), 32'h0);
        chk("c0_addr", imem_addr, 32'h1eceb104);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("c0h_inst", inst, 32'hC0000000);
        chk("c0h_pc", inst_pc, 32'h1eceb100);
        chk("c0h_pcnext", inst_pc_next, 32'h1eceb104);

        // Two redirects while dropping: only the second target is fetched
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h1eceb300);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h1eceb400);
        chk("rb_valid", 32'(inst_valid), 32'h0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        chk("rb_addr", imem_addr, 32'h1eceb400);
        chk("rb_rmask", 32'(imem_rmask), 32'hF);
        cyc(1'b1, 32'hE0000000, 1'b0, 1'b0, 32'h0);
        chk("rb1_addr", imem_addr, 32'h1eceb404);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rb2_pc", inst_pc, 32'h1eceb400);
        chk("rb2_inst", inst, 32'hE0000000);

        // Reset mid-operation with two entries queued and a request outstanding
        cyc(1'b1, 32'hE0000001, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_addr", imem_addr, 32'h1eceb408);
        @(negedge clk);
        rst = 1'b0; imem_resp = 1'b0;
        #1;
        chk("mrst_valid", 32'(inst_valid), 32'h0);
        chk("mrst_rmask", 32'(imem_rmask), 32'h0);
        cyc(1'b1, 32'hBAD00000, 1'b0, 1'b0, 32'h0);
        chk("mrst_hold_rmask", 32'(imem_rmask), 32'h0);
        @(negedge clk);
        rst = 1'b1; imem_resp = 1'b1; imem_rdata = 32'hBAD00001;
        #1;
        chk("rs_rmask", 32'(imem_rmask), 32'hF);
        chk("rs_addr", imem_addr, 32'h1eceb000);
        chk("rs_valid", 32'(inst_valid), 32'h0);
        cyc(1'b1, 32'hF0000000, 1'b0, 1'b0, 32'h0);
        chk("rs1_addr", imem_addr, 32'h1eceb004);
        chk("rs1_valid", 32'(inst_valid), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rs2_inst", inst, 32'hF0000000);
        chk("rs2_pc", inst_pc, 32'h1eceb000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the decode stage. It owns the architectural fetch PC and issues word reads on the instruction memory port, at most one outstanding at a time. Returned words go into a small FIFO that decouples variable imem latency from decode stalls. It also handles control-flow redirects from execute by flushing the FIFO and discarding any stale in-flight response.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h1eceb000, first fetch address after reset
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; asynchronous, active-low
- imem_addr  out  32  fetch address, word-aligned; equals `pc` whenever `imem_rmask` != 0
- imem_rmask  out  4  4'hF for exactly one cycle per request, otherwise 4'h0
- imem_rdata  in  32  instruction word; valid only when `imem_resp` = 1
- imem_resp  in  1  one-cycle pulse completing the outstanding request
- redirect_valid  in  1  execute-stage redirect; one cycle per event
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0
- inst_valid  out  1  FIFO head is valid
- inst_ready  in  1  decode accepts the head this cycle; low means stall
- inst  out  32  head instruction word
- inst_pc  out  32  head PC
- inst_pc_next  out  32  inst_pc + 4

## Operation
- Each FIFO entry holds {word, pc}. Entries are tracked with a count of width $clog2(DEPTH)+1, plus rd/wr pointers that wrap modulo DEPTH.
- The fetch FSM has three states:
  - IDLE: no outstanding request.
  - WAIT: one request outstanding; its response will be kept.
  - DROP: one request outstanding; its response will be discarded.
- issue = !redirect_valid && (state==IDLE || (state!=IDLE && imem_resp)) && (count + (state==WAIT)) < DEPTH.
  - The space check uses registered count only. A pop in the same cycle does not enable an issue.
- On issue:
  - imem_rmask = 4'hF and imem_addr = pc.
  - The request PC is latched as req_pc.
  - pc <= pc + 4 (32-bit wrap allowed).
  - Next state is WAIT.
- On imem_resp in WAIT with no redirect: push {imem_rdata, req_pc}. Next state is WAIT if issue, else IDLE.
- On imem_resp in DROP: no push. Next state is WAIT if issue, else IDLE.
- On redirect_valid:
  - Highest priority in all states.
  - FIFO is flushed: count, rd and wr all go to 0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No issue and no push in that cycle.
  - Next state: from IDLE, IDLE. From WAIT or DROP, DROP if imem_resp = 0, else IDLE (the response is stale and consumed).
- Pop: inst_valid = (count != 0) && !redirect_valid. A pop occurs when inst_valid && inst_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push with count == DEPTH cannot occur, because the space check prevents it.
- imem_resp in IDLE is a protocol violation. It is ignored: no push and no state change.

## Timing
- Reset values:
  - pc = RESET_PC, state = IDLE, count = 0, pointers = 0.
  - imem_rmask = 0, inst_valid = 0.
  - inst, inst_pc and inst_pc_next are don't-care while inst_valid = 0.
- After reset deasserts, the first issue (imem_addr = RESET_PC) occurs in the first cycle.
- Latency:
  - A response at cycle t is visible as the FIFO head at t+1 when the FIFO was empty.
  - A pop at t+1 frees that entry.
- Throughput: one instruction per cycle with single-cycle imem (issue in the response cycle).
- Combinational paths:
  - imem_resp and redirect_valid → imem_rmask.
  - redirect_valid → inst_valid.
  - There is no path from inst_ready to imem_rmask.
- Reset asserted mid-operation: immediately returns all state to reset values. A later imem_resp belonging to a pre-reset request is ignored (state IDLE).

## Structure
- Add fetch_state_t (IDLE/WAIT/DROP) and fq_entry_t {logic [31:0] inst; logic [31:0] pc;} to rv32i_types.
- RESET_PC defaults to the same constant the CPU top uses.
- The FIFO storage is a natural sub-module, fq_fifo, parameterised on DEPTH. It has push, pop and flush inputs, count/head outputs, and receives the same asynchronous reset.
- The FSM and pc live in fetch_queue.

## Test plan
- Reset, single-cycle imem, inst_ready=1 → requests at 1eceb000, 1eceb004, …, one per cycle; inst_pc matches each, inst_pc_next = inst_pc+4.
- inst_ready=0, DEPTH=4, 1-cycle imem → exactly 4 requests issued, then imem_rmask stays 0; raising inst_ready for one cycle allows exactly one new issue the next cycle.
- imem latency 3 cycles, redirect_valid with redirect_pc=32'h1eceb103 during WAIT → FIFO empties, stale response dropped (no inst_valid), next request at 32'h1eceb100 in the response cycle.
- redirect in same cycle as imem_resp in WAIT → response dropped, state IDLE, request to redirect target one cycle later.
- Two redirects (A then B) while in DROP → only B fetched; no entry with pc A ever appears.
- rst asserted while in WAIT with 2 entries queued → inst_valid and imem_rmask go 0 immediately; a late imem_resp pulse is ignored; fetch restarts at RESET_PC.
